// File: rtl/dac_path_arbiter_pkg.sv
// Shared definitions for the DAC path arbiter: FSM states and default timing.
package dac_path_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GUARD = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam int DEF_GUARD_CYCLES = 16;
  localparam int DEF_BUSY_CYCLES  = 6;
  localparam int DEF_UCOUNT_W     = 16;

  // ready/underrun are only steered to a DAC while one is granted
  function automatic logic is_routing(input state_t s);
    return (s == RUN) || (s == DRAIN);
  endfunction

endpackage

// File: rtl/dac_path_arbiter_if.sv
// Bundle of buffer-side and DAC-side signals around the DAC path arbiter.
interface dac_path_arbiter_if
  import dac_path_arbiter_pkg::*;
#(
  parameter int UCOUNT_W = DEF_UCOUNT_W
);
  logic                sel_bist;
  logic                dac_open;
  logic                buf_request;
  logic                buf_ready;
  logic                buf_underrun;
  logic                src_request;
  logic                src_ready;
  logic                src_underrun;
  logic                src_reset;
  logic                bist_request;
  logic                bist_ready;
  logic                bist_underrun;
  logic                bist_reset;
  logic                active_bist;
  logic [UCOUNT_W-1:0] underrun_count;
  logic [UCOUNT_W-1:0] collision_count;

  modport master (
    input  sel_bist, dac_open, buf_ready, buf_underrun, src_request, bist_request,
    output buf_request, src_ready, src_underrun, src_reset,
    output bist_ready, bist_underrun, bist_reset, active_bist,
    output underrun_count, collision_count
  );

  modport slave (
    output sel_bist, dac_open, buf_ready, buf_underrun, src_request, bist_request,
    input  buf_request, src_ready, src_underrun, src_reset,
    input  bist_ready, bist_underrun, bist_reset, active_bist,
    input  underrun_count, collision_count
  );
endinterface

// File: rtl/dac_path_arbiter_sat_counter.sv
// Saturating event counter: counts inc cycles, sticks at all-ones.
module dac_path_arbiter_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Increment on each inc cycle until the counter is full
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/dac_path_arbiter.sv
// Shares the single DAC buffer between the source DAC and the BIST DAC:
// grants one DAC at a time, spaces forwarded requests, and keeps DACs in
// reset while ungranted or while the grant is being switched.
module dac_path_arbiter
  import dac_path_arbiter_pkg::*;
#(
  parameter int GUARD_CYCLES = DEF_GUARD_CYCLES,
  parameter int BUSY_CYCLES  = DEF_BUSY_CYCLES,
  parameter int UCOUNT_W     = DEF_UCOUNT_W
) (
  input logic               capture_clk,
  input logic               reset,
  dac_path_arbiter_if.master bus
);

  localparam int GW = $clog2(GUARD_CYCLES + 1);
  localparam int BW = $clog2(BUSY_CYCLES + 1);
  localparam logic [GW-1:0] GUARD_LAST = GW'(GUARD_CYCLES - 1);
  // loaded on the forwarding edge, so the remaining BUSY_CYCLES-1 cycles are blocked
  localparam logic [BW-1:0] BUSY_LOAD  = BW'(BUSY_CYCLES - 1);

  state_t        state;
  logic [GW-1:0] guard_cnt;
  logic [BW-1:0] busy_cnt;
  logic          busy;
  logic          sel_req;
  logic          collide;
  logic          route;

  assign busy    = (busy_cnt != '0);
  assign sel_req = bus.active_bist ? bus.bist_request : bus.src_request;
  assign route   = is_routing(state);
  assign collide = bus.dac_open && route && sel_req && busy;

  assign bus.src_ready     = route && !bus.active_bist && bus.buf_ready;
  assign bus.src_underrun  = route && !bus.active_bist && bus.buf_underrun;
  assign bus.bist_ready    = route &&  bus.active_bist && bus.buf_ready;
  assign bus.bist_underrun = route &&  bus.active_bist && bus.buf_underrun;

  // Grant FSM with busy-window timer; all DAC-facing controls are registered
  always_ff @(posedge capture_clk) begin
    if (reset) begin
      state           <= IDLE;
      guard_cnt       <= '0;
      busy_cnt        <= '0;
      bus.buf_request <= 1'b0;
      bus.src_reset   <= 1'b1;
      bus.bist_reset  <= 1'b1;
      bus.active_bist <= 1'b0;
    end else begin
      bus.buf_request <= 1'b0;
      if (busy) busy_cnt <= busy_cnt - BW'(1);
      if ((state != IDLE) && !bus.dac_open) begin
        state          <= IDLE;
        busy_cnt       <= '0;
        bus.src_reset  <= 1'b1;
        bus.bist_reset <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            if (bus.dac_open) begin
              bus.active_bist <= bus.sel_bist;
              guard_cnt       <= '0;
              state           <= GUARD;
            end
          end
          GUARD: begin
            if (guard_cnt == GUARD_LAST) begin
              state          <= RUN;
              bus.src_reset  <= bus.active_bist;
              bus.bist_reset <= !bus.active_bist;
            end else begin
              guard_cnt <= guard_cnt + GW'(1);
            end
          end
          RUN: begin
            if (bus.sel_bist != bus.active_bist) begin
              state <= DRAIN;
            end else if (sel_req && !busy) begin
              bus.buf_request <= 1'b1;
              busy_cnt        <= BUSY_LOAD;
            end
          end
          DRAIN: begin
            // the buffer must finish its read before the new DAC owns it
            if (!busy) begin
              bus.active_bist <= bus.sel_bist;
              bus.src_reset   <= 1'b1;
              bus.bist_reset  <= 1'b1;
              guard_cnt       <= '0;
              state           <= GUARD;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  dac_path_arbiter_sat_counter #(.W(UCOUNT_W)) u_underrun_cnt (
    .clk   (capture_clk),
    .rst   (reset),
    .inc   (bus.buf_underrun),
    .count (bus.underrun_count)
  );

  dac_path_arbiter_sat_counter #(.W(UCOUNT_W)) u_collision_cnt (
    .clk   (capture_clk),
    .rst   (reset),
    .inc   (collide),
    .count (bus.collision_count)
  );

endmodule
